// File: rtl/sys_defs.sv
// Shared checkpoint types and the history shift helper for the global history manager.
// GHR_ARCH_RECOVER_EN adds a per-entry resolved direction used by architectural recovery.
`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 16
`endif

package sys_defs;
   localparam int GHR_BHT_DEPTH  = `BRANCH_HISTORY_TABLE_SIZE;
   localparam int GHR_HIST_W     = $clog2(GHR_BHT_DEPTH);
   localparam int GHR_CKPT_DEPTH = 8;
   localparam int GHR_TAG_W      = $clog2(GHR_CKPT_DEPTH);

   typedef logic [GHR_TAG_W-1:0]  GHR_TAG;
   typedef logic [GHR_HIST_W-1:0] GHR_HIST;

   typedef struct packed {
      GHR_HIST hist;
      GHR_HIST index;
      logic    pred;
`ifdef GHR_ARCH_RECOVER_EN
      logic    dir;
`endif
      logic    resolved;
      logic    valid;
   } GHR_CKPT_ENTRY;

   function automatic GHR_HIST ghr_shift(input GHR_HIST h, input logic dir);
      return {h[GHR_HIST_W-2:0], dir};
   endfunction
endpackage

// File: rtl/ghr_ckpt_buffer.sv
// Circular checkpoint store with head/tail/count and truncate-to-tag on mispredict; reads are
// combinational, updates land on the next edge. GHR_ARCH_RECOVER_EN adds flush_all and head_dir.
module ghr_ckpt_buffer
   import sys_defs::*;
#(
   parameter int DEPTH = GHR_CKPT_DEPTH,
   localparam int T = $clog2(DEPTH)
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic [GHR_HIST_W-1:0] push_hist,
   input  logic [GHR_HIST_W-1:0] push_index,
   input  logic                  push_pred,
   input  logic                  res_valid,
   input  logic [T-1:0]          res_tag,
   input  logic                  res_taken,
   input  logic                  res_mispred,
   input  logic                  retire_valid,
`ifdef GHR_ARCH_RECOVER_EN
   input  logic                  flush_all,
   output logic                  head_dir,
`endif
   output logic [T-1:0]          tail,
   output logic [T:0]            count,
   output logic [GHR_HIST_W-1:0] res_hist,
   output logic [GHR_HIST_W-1:0] res_index
);
   GHR_CKPT_ENTRY ent [DEPTH];
   logic [T-1:0]  head;
   logic [T-1:0]  res_dist;
   logic          retire_ok;
   logic          trunc;

   assign retire_ok = retire_valid && (count != '0);
   assign trunc     = res_valid && res_mispred;
   assign res_dist  = res_tag - head;
   assign res_hist  = ent[res_tag].hist;
   assign res_index = ent[res_tag].index;
`ifdef GHR_ARCH_RECOVER_EN
   assign head_dir  = ent[head].dir;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end
`ifdef GHR_ARCH_RECOVER_EN
      else if (flush_all) begin
         head  <= tail;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      end
`endif
      else begin
         // Younger than the mispredicted branch means farther from head than it.
         for (int i = 0; i < DEPTH; i++) begin
            if (trunc && ((T'(i) - head) > res_dist)) ent[i].valid <= 1'b0;
         end
         if (res_valid) begin
            ent[res_tag].resolved <= 1'b1;
`ifdef GHR_ARCH_RECOVER_EN
            ent[res_tag].dir      <= res_taken;
`endif
         end
         if (retire_ok) begin
            ent[head].valid <= 1'b0;
            head            <= head + T'(1);
         end
         if (push) begin
            ent[tail].hist     <= push_hist;
            ent[tail].index    <= push_index;
            ent[tail].pred     <= push_pred;
            ent[tail].resolved <= 1'b0;
            ent[tail].valid    <= 1'b1;
`ifdef GHR_ARCH_RECOVER_EN
            ent[tail].dir      <= 1'b0;
`endif
         end
         if (trunc) begin
            tail  <= res_tag + T'(1);
            count <= (T+1)'(res_dist) + (T+1)'(1) - (T+1)'(retire_ok);
         end else begin
            tail  <= tail + T'(push);
            count <= count + (T+1)'(push) - (T+1)'(retire_ok);
         end
      end
   end

   a_res_tag_valid : assert property (@(posedge clock) disable iff (reset)
      res_valid |-> ent[res_tag].valid);
   a_mispred_consistent : assert property (@(posedge clock) disable iff (reset)
      res_valid |-> (res_mispred == (res_taken != ent[res_tag].pred)));
   a_no_resolve_retire_same : assert property (@(posedge clock) disable iff (reset)
      (res_valid && retire_ok) |-> (res_tag != head));
   a_retire_resolved : assert property (@(posedge clock) disable iff (reset)
      retire_ok |-> ent[head].resolved);
endmodule

// File: rtl/ghr_checkpoint.sv
// Speculative global history for gshare with per-branch checkpoints; predictor write port is 1-cycle registered.
// push_ready drops when full or on a mispredict; GHR_ARCH_RECOVER_EN adds flush_all and arch_hist recovery.
module ghr_checkpoint
   import sys_defs::*;
#(
   parameter int BHT_DEPTH  = GHR_BHT_DEPTH,
   parameter int CKPT_DEPTH = GHR_CKPT_DEPTH,
   localparam int H = $clog2(BHT_DEPTH),
   localparam int T = $clog2(CKPT_DEPTH)
)(
   input  logic         clock,
   input  logic         reset,
   input  logic         push_valid,
   input  logic         push_pred,
   input  logic [H-1:0] push_index,
   output logic         push_ready,
   output logic [T-1:0] push_tag,
   output logic [H-1:0] rd_bhr,
   input  logic         res_valid,
   input  logic [T-1:0] res_tag,
   input  logic         res_taken,
   input  logic         res_mispred,
   input  logic         retire_valid,
`ifdef GHR_ARCH_RECOVER_EN
   input  logic         flush_all,
`endif
   output logic         wr_en,
   output logic         wr_taken,
   output logic [H-1:0] wr_index,
   output logic [T:0]   count
);
   logic [H-1:0] spec_hist;
   logic [H-1:0] res_hist;
   logic [H-1:0] res_index;
   logic [T-1:0] tail;
   logic         mispred;
   logic         push_fire;
`ifdef GHR_ARCH_RECOVER_EN
   logic [H-1:0] arch_hist;
   logic         head_dir;
`endif

   assign mispred    = res_valid && res_mispred;
   assign push_ready = (count != (T+1)'(CKPT_DEPTH)) && !mispred;
   assign push_fire  = push_valid && push_ready;
   assign push_tag   = tail;
   assign rd_bhr     = spec_hist;

   ghr_ckpt_buffer #(.DEPTH(CKPT_DEPTH)) u_buf (
      .clock        (clock),
      .reset        (reset),
      .push         (push_fire),
      .push_hist    (spec_hist),
      .push_index   (push_index),
      .push_pred    (push_pred),
      .res_valid    (res_valid),
      .res_tag      (res_tag),
      .res_taken    (res_taken),
      .res_mispred  (res_mispred),
      .retire_valid (retire_valid),
`ifdef GHR_ARCH_RECOVER_EN
      .flush_all    (flush_all),
      .head_dir     (head_dir),
`endif
      .tail         (tail),
      .count        (count),
      .res_hist     (res_hist),
      .res_index    (res_index)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         spec_hist <= '0;
      end
`ifdef GHR_ARCH_RECOVER_EN
      else if (flush_all) begin
         spec_hist <= arch_hist;
      end
`endif
      else if (mispred) begin
         spec_hist <= ghr_shift(res_hist, res_taken);
      end else if (push_fire) begin
         spec_hist <= ghr_shift(spec_hist, push_pred);
      end
   end

`ifdef GHR_ARCH_RECOVER_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         arch_hist <= '0;
      end else if (!flush_all && retire_valid && (count != '0)) begin
         arch_hist <= ghr_shift(arch_hist, head_dir);
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_en    <= 1'b0;
         wr_taken <= 1'b0;
         wr_index <= '0;
      end else begin
`ifdef GHR_ARCH_RECOVER_EN
         wr_en <= res_valid && !flush_all;
`else
         wr_en <= res_valid;
`endif
         if (res_valid) begin
            wr_taken <= res_taken;
            wr_index <= res_index;
         end
      end
   end
endmodule

// File: tb/tb_ghr_checkpoint.sv
// Directed bench for ghr_checkpoint (H=4, 8 checkpoints); define GHR_ARCH_RECOVER_EN to cover flush_all.
module tb_ghr_checkpoint;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       push_valid = 1'b0;
   logic       push_pred = 1'b0;
   logic [3:0] push_index = '0;
   logic       push_ready;
   logic [2:0] push_tag;
   logic [3:0] rd_bhr;
   logic       res_valid = 1'b0;
   logic [2:0] res_tag = '0;
   logic       res_taken = 1'b0;
   logic       res_mispred = 1'b0;
   logic       retire_valid = 1'b0;
   logic       flush_all = 1'b0;
   logic       wr_en;
   logic       wr_taken;
   logic [3:0] wr_index;
   logic [3:0] count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   ghr_checkpoint dut (
      .clock        (clock),
      .reset        (reset),
      .push_valid   (push_valid),
      .push_pred    (push_pred),
      .push_index   (push_index),
      .push_ready   (push_ready),
      .push_tag     (push_tag),
      .rd_bhr       (rd_bhr),
      .res_valid    (res_valid),
      .res_tag      (res_tag),
      .res_taken    (res_taken),
      .res_mispred  (res_mispred),
      .retire_valid (retire_valid),
`ifdef GHR_ARCH_RECOVER_EN
      .flush_all    (flush_all),
`endif
      .wr_en        (wr_en),
      .wr_taken     (wr_taken),
      .wr_index     (wr_index),
      .count        (count)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      push_valid = 0; push_pred = 0; push_index = 0;
      res_valid = 0; res_tag = 0; res_taken = 0; res_mispred = 0;
      retire_valid = 0; flush_all = 0;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1;
      tick();
      reset = 0;
      #1;
   endtask

   task automatic push(input logic pred, input logic [3:0] idx);
      push_valid = 1; push_pred = pred; push_index = idx;
      tick();
      push_valid = 0; push_pred = 0; push_index = 0;
   endtask

   task automatic resolve(input logic [2:0] tag, input logic taken, input logic mis);
      res_valid = 1; res_tag = tag; res_taken = taken; res_mispred = mis;
      tick();
      res_valid = 0; res_tag = 0; res_taken = 0; res_mispred = 0;
   endtask

   task automatic retire();
      retire_valid = 1;
      tick();
      retire_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%0d want=1", push_ready); end
      total++; if (push_tag !== 3'd0) begin bad++; $display("FAIL reset_push_tag got=%0d want=0", push_tag); end
      total++; if (rd_bhr !== 4'h0) begin bad++; $display("FAIL reset_rd_bhr got=%h want=0", rd_bhr); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if ({wr_en, wr_taken, wr_index} !== 6'd0) begin bad++; $display("FAIL reset_wr got=%b%b%h want=000", wr_en, wr_taken, wr_index); end
      push(1, 4'h5);
      push(1, 4'h6);
      resolve(0, 1, 0);
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL pre_reset_wr_en got=%0d want=1", wr_en); end
      #2 reset = 1;
      #1;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", count); end
      total++; if (rd_bhr !== 4'h0) begin bad++; $display("FAIL midreset_rd_bhr got=%h want=0", rd_bhr); end
      total++; if ({wr_en, wr_index} !== 5'd0) begin bad++; $display("FAIL midreset_wr got=%b/%h want=0/0", wr_en, wr_index); end
      total++; if (push_tag !== 3'd0) begin bad++; $display("FAIL midreset_push_tag got=%0d want=0", push_tag); end
      tick();
      reset = 0;
      #1;
   endtask

   task automatic test_push_basic();
      logic [2:0] preds;
      logic [11:0] bhrs;
      preds = 3'b101;
      bhrs  = {4'h5, 4'h2, 4'h1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push_valid = 1; push_pred = preds[i]; push_index = 4'(i);
         #1;
         total++; if (push_tag !== 3'(i)) begin bad++; $display("FAIL push_tag%0d got=%0d want=%0d", i, push_tag, i); end
         tick();
         push_valid = 0;
         total++; if (rd_bhr !== bhrs[i*4 +: 4]) begin bad++; $display("FAIL push_bhr%0d got=%h want=%h", i, rd_bhr, bhrs[i*4 +: 4]); end
      end
      total++; if (count !== 4'd3) begin bad++; $display("FAIL push_count got=%0d want=3", count); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) push(1, 4'(i));
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", count); end
      total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0d want=0", push_ready); end
      total++; if (rd_bhr !== 4'hF) begin bad++; $display("FAIL full_bhr got=%h want=f", rd_bhr); end
      push(0, 4'h0);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_ignored_count got=%0d want=8", count); end
      total++; if (rd_bhr !== 4'hF) begin bad++; $display("FAIL full_ignored_bhr got=%h want=f", rd_bhr); end
      resolve(0, 1, 0);
      retire();
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL full_retire_ready got=%0d want=1", push_ready); end
      total++; if (count !== 4'd7) begin bad++; $display("FAIL full_retire_count got=%0d want=7", count); end
   endtask

   task automatic test_mispredict();
      do_reset();
      push(1, 0); push(0, 0); push(1, 0); push(0, 0);
      total++; if (rd_bhr !== 4'hA) begin bad++; $display("FAIL mis_pre_bhr got=%h want=a", rd_bhr); end
      res_valid = 1; res_tag = 1; res_taken = 1; res_mispred = 1;
      #1;
      total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL mis_ready got=%0d want=0", push_ready); end
      tick();
      clear_in();
      #1;
      total++; if (rd_bhr !== 4'h3) begin bad++; $display("FAIL mis_bhr got=%h want=3", rd_bhr); end
      total++; if (count !== 4'd2) begin bad++; $display("FAIL mis_count got=%0d want=2", count); end
      total++; if (push_tag !== 3'd2) begin bad++; $display("FAIL mis_tail got=%0d want=2", push_tag); end
      total++; if ({wr_en, wr_taken} !== 2'b11) begin bad++; $display("FAIL mis_wr got=%b%b want=11", wr_en, wr_taken); end
      push(1, 0);
      total++; if (rd_bhr !== 4'h7) begin bad++; $display("FAIL mis_repush_bhr got=%h want=7", rd_bhr); end
      total++; if (count !== 4'd3) begin bad++; $display("FAIL mis_repush_count got=%0d want=3", count); end
   endtask

   task automatic test_resolve();
      do_reset();
      push(1, 4'h3); push(0, 4'h5); push(1, 4'h9);
      resolve(2, 1, 0);
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL res_wr_en got=%0d want=1", wr_en); end
      total++; if (wr_index !== 4'h9) begin bad++; $display("FAIL res_wr_index got=%h want=9", wr_index); end
      total++; if (wr_taken !== 1'b1) begin bad++; $display("FAIL res_wr_taken got=%0d want=1", wr_taken); end
      total++; if (rd_bhr !== 4'h5) begin bad++; $display("FAIL res_bhr got=%h want=5", rd_bhr); end
      total++; if (count !== 4'd3) begin bad++; $display("FAIL res_count got=%0d want=3", count); end
      tick();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL res_wr_en_drop got=%0d want=0", wr_en); end
      resolve(0, 0, 1);
      total++; if ({wr_en, wr_taken, wr_index} !== 6'b10_0011) begin bad++; $display("FAIL res_tag0_wr got=%b%b%h want=103", wr_en, wr_taken, wr_index); end
   endtask

   task automatic test_mispred_push();
      do_reset();
      push(1, 0); push(0, 0);
      res_valid = 1; res_tag = 1; res_taken = 1; res_mispred = 1;
      push_valid = 1; push_pred = 1;
      #1;
      total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL mp_ready got=%0d want=0", push_ready); end
      tick();
      clear_in();
      #1;
      total++; if (count !== 4'd2) begin bad++; $display("FAIL mp_count got=%0d want=2", count); end
      total++; if (rd_bhr !== 4'h3) begin bad++; $display("FAIL mp_bhr got=%h want=3", rd_bhr); end
      total++; if (push_tag !== 3'd2) begin bad++; $display("FAIL mp_tail got=%0d want=2", push_tag); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 6; i++) push(0, 0);
      for (int i = 0; i < 6; i++) begin
         resolve(3'(i), 0, 0);
         retire();
      end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_drain_count got=%0d want=0", count); end
      total++; if (push_tag !== 3'd6) begin bad++; $display("FAIL wrap_tail got=%0d want=6", push_tag); end
      for (int i = 0; i < 6; i++) push(1, 4'(i));
      total++; if (count !== 4'd6) begin bad++; $display("FAIL wrap_fill_count got=%0d want=6", count); end
      total++; if (push_tag !== 3'd4) begin bad++; $display("FAIL wrap_fill_tail got=%0d want=4", push_tag); end
      resolve(1, 0, 1);
      total++; if (count !== 4'd4) begin bad++; $display("FAIL wrap_mis_count got=%0d want=4", count); end
      total++; if (rd_bhr !== 4'hE) begin bad++; $display("FAIL wrap_mis_bhr got=%h want=e", rd_bhr); end
      total++; if (push_tag !== 3'd2) begin bad++; $display("FAIL wrap_mis_tail got=%0d want=2", push_tag); end
      total++; if (wr_index !== 4'h3) begin bad++; $display("FAIL wrap_mis_index got=%h want=3", wr_index); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push(1, 0); push(1, 0);
      resolve(0, 1, 0);
      retire_valid = 1; push_valid = 1; push_pred = 0;
      #1;
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0d want=1", push_ready); end
      total++; if (push_tag !== 3'd2) begin bad++; $display("FAIL b2b_tag got=%0d want=2", push_tag); end
      tick();
      clear_in();
      total++; if (count !== 4'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", count); end
      total++; if (rd_bhr !== 4'h6) begin bad++; $display("FAIL b2b_bhr got=%h want=6", rd_bhr); end
      do_reset();
      retire();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL empty_retire_count got=%0d want=0", count); end
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL empty_retire_ready got=%0d want=1", push_ready); end
   endtask

`ifdef GHR_ARCH_RECOVER_EN
   task automatic test_arch_recover();
      do_reset();
      push(1, 0); push(0, 0);
      resolve(0, 1, 0);
      resolve(1, 0, 0);
      retire(); retire();
      push(1, 0); push(1, 0);
      flush_all = 1;
      tick();
      flush_all = 0;
      #1;
      total++; if (rd_bhr !== 4'h2) begin bad++; $display("FAIL arch_bhr got=%h want=2", rd_bhr); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL arch_count got=%0d want=0", count); end
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL arch_ready got=%0d want=1", push_ready); end
      total++; if (push_tag !== 3'd4) begin bad++; $display("FAIL arch_tail got=%0d want=4", push_tag); end
   endtask
`endif

   initial begin
      test_reset();
      test_push_basic();
      test_full();
      test_mispredict();
      test_resolve();
      test_mispred_push();
      test_wrap();
      test_back_to_back();
`ifdef GHR_ARCH_RECOVER_EN
      test_arch_recover();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ghr_checkpoint.md
Name: ghr_checkpoint

Overview:
- Global branch history manager feeding the gshare predictor.
- Supplies the speculative history that the predictor XORs with the fetch PC.
- At fetch, checkpoints each branch's pre-update history and its predictor index into a circular buffer.
- On resolve, drives the predictor's counter-update port; on mispredict, repairs the history and squashes younger checkpoints.

Parameters:
- BHT_DEPTH, `BRANCH_HISTORY_TABLE_SIZE, predictor table size; history width H = $clog2(BHT_DEPTH)
- CKPT_DEPTH, 8, max in-flight branches (power of 2); tag width T = $clog2(CKPT_DEPTH)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- push_valid  in  1  fetch has a conditional branch this cycle
- push_pred  in  1  predicted direction from the predictor
- push_index  in  H  predictor out_index for this branch
- push_ready  out  1  checkpoint slot available
- push_tag  out  T  slot allocated when push_valid && push_ready
- rd_bhr  out  H  current speculative history, to predictor rd_bhr
- res_valid  in  1  branch resolved in execute
- res_tag  in  T  tag of the resolved branch
- res_taken  in  1  actual direction
- res_mispred  in  1  actual direction differs from push_pred
- retire_valid  in  1  oldest branch commits
- wr_en  out  1  to predictor wr_en
- wr_taken  out  1  to predictor wr_taken
- wr_index  out  H  to predictor wr_index
- count  out  T+1  occupied slots

Behaviour:
- Reset: all outputs 0 except push_ready=1; spec history=0, head=tail=0, all entry valid bits cleared. Takes effect immediately and mid-operation; in-flight state is discarded.
- Shift rule: next = {hist[H-2:0], dir}; the oldest bit drops.
- Entry fields: hist (pre-update history), index, pred.
- push_ready = (count != CKPT_DEPTH) && !(res_valid && res_mispred). Combinational; does not depend on push_valid.
- Push: when push_valid && push_ready, write entry[tail], push_tag = tail, tail++ (wraps mod CKPT_DEPTH), spec_hist <= shift(spec_hist, push_pred). rd_bhr reflects the new value the next cycle.
- Resolve: one cycle after res_valid:
  - wr_en=1, wr_taken=res_taken, wr_index=entry[res_tag].index.
  - Outputs are registered, so latency is 1 cycle.
  - wr_en is 0 in all other cycles.
- Mispredict (res_valid && res_mispred):
  - spec_hist <= shift(entry[res_tag].hist, res_taken).
  - tail <= res_tag+1; entries younger than res_tag are invalidated.
  - count <= (res_tag - head mod CKPT_DEPTH) + 1.
  - A same-cycle push is ignored because push_ready is low.
- Retire: on retire_valid, head++ and count--. Retire with count==0 is ignored.
- Same-cycle retire and push are both honoured. push_ready uses the registered count, so there is no full bypass.
- Illegal, covered by assertions: res_tag not valid; resolve and retire of the same tag in the same cycle; retire while the head is unresolved.
- Out-of-order resolves are allowed; an entry's resolved bit is set on resolve.

Optional Feature:
- GHR_ARCH_RECOVER_EN.
- When defined:
  - Adds input flush_all.
  - Keeps arch_hist, updated at retire as shift(arch_hist, resolved direction).
  - Each entry stores its resolved direction for this update.
  - On flush_all: spec_hist <= arch_hist, head=tail, count=0, all entries invalid.
  - flush_all has priority over push, resolve and retire.
- When undefined: no port, no arch_hist, no storage for the resolved direction.

Decomposition:
- Shared package (sys_defs): GHR_CKPT_DEPTH constant; typedef GHR_CKPT_ENTRY {hist, index, pred, resolved, valid}; typedef GHR_TAG.
- One sub-module, ghr_ckpt_buffer: circular storage with head/tail/count and truncate-to-tag.
- The top level holds spec_hist, the shift logic and the predictor write port.

Test Plan:
- Reset, then 3 pushes with pred 1,0,1 -> tags 0,1,2; rd_bhr 0 -> 1 -> 2 -> 5 (H=4); count=3.
- Push 8 branches without retire -> push_ready=0 after the 8th; a 9th push_valid is ignored; one retire -> push_ready=1 the next cycle.
- Tags 0..3 pushed (hist 0,1,2,5), mispredict tag 1 taken -> next cycle rd_bhr=shift(1,1)=3, count=2, tail=2; next push gets tag 2.
- Resolve tag 2 not mispredicted, index 0x9, taken -> next cycle wr_en=1, wr_index=9, wr_taken=1; the following cycle wr_en=0.
- Mispredict plus push_valid in the same cycle -> push dropped, push_ready=0 that cycle; wrap test: head=6, mispredict tag 1 -> count=4.
- GHR_ARCH_RECOVER_EN: retire two branches taken,not-taken (arch=2), push 2 more, flush_all -> rd_bhr=2, count=0, push_ready=1.
